// File: rtl/conv_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// conv_ctrl_fsm_if
// Shared con_1..3 bus handshake and result-report signals between the host
// and the convolution sequencer.
//   con_valid     host -> chip   host has a valid beat on con_1..3
//   con_ready     chip -> host   controller accepts the beat this cycle
//   driving_cons  chip -> host   chip owns con_1..3
//   output_valid  chip -> host   a result is on the bus this cycle
//   output_x/y/ch chip -> host   coordinates of the driven result
// master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface conv_ctrl_fsm_if #(
    parameter int XW = 10,
    parameter int YW = 10,
    parameter int CW = 6
);
    logic          con_valid;
    logic          con_ready;
    logic          driving_cons;
    logic          output_valid;
    logic [XW-1:0] output_x;
    logic [YW-1:0] output_y;
    logic [CW-1:0] output_ch;

    modport master (
        output con_valid,
        input  con_ready, driving_cons, output_valid, output_x, output_y, output_ch
    );

    modport slave (
        input  con_valid,
        output con_ready, driving_cons, output_valid, output_x, output_y, output_ch
    );
endinterface

// File: rtl/conv_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// conv_ctrl_fsm
// Sequencer for the convolution datapath (input shift stage, kernel store,
// 36-lane MAC, output stage). Walks y -> x -> output channel -> input group,
// loads 12 kernel beats and 12 input beats per group over the shared bus,
// then drains the MAC and turns the bus around to drive one result.
// Ports:
//   clk, arst_n_in        clock, asynchronous active-low reset
//   start                 begins a layer when idle (ignored while running)
//   running               high from start acceptance until last result driven
//   bus (slave)           con_valid/con_ready handshake, bus ownership,
//                         output_valid and output coordinates
//   ctrl_*                datapath enables and selects
// All outputs decode from registered state only; the kernel/input load
// enables are additionally qualified by the accepted-beat strobe.
// ---------------------------------------------------------------------------
module conv_ctrl_fsm #(
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int INPUT_NB_CHANNELS  = 64,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int MAC_LATENCY        = 2
) (
    input  logic                 clk,
    input  logic                 arst_n_in,
    input  logic                 start,
    output logic                 running,
    conv_ctrl_fsm_if.slave       bus,
    output logic [11:0]          ctrl_KDS_LE_select,
    output logic [1:0]           ctrl_IDSS_LE_select,
    output logic                 ctrl_IDSS_shift,
    output logic                 ctrl_MAC_en,
    output logic                 ctrl_MAC_acc_first,
    output logic                 ctrl_ODS_shift,
    output logic [1:0]           ctrl_ODS_sel_out
);
    localparam int XW = $clog2(FEATURE_MAP_WIDTH);
    localparam int YW = $clog2(FEATURE_MAP_HEIGHT);
    localparam int CW = $clog2(OUTPUT_NB_CHANNELS);
    localparam int G  = INPUT_NB_CHANNELS / 4;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int DW = $clog2(MAC_LATENCY + 1);

    localparam logic [XW-1:0] X_LAST  = XW'(FEATURE_MAP_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [CW-1:0] CH_LAST = CW'(OUTPUT_NB_CHANNELS - 1);
    localparam logic [GW-1:0] G_LAST  = GW'(G - 1);
    localparam logic [DW-1:0] D_LAST  = DW'(MAC_LATENCY - 1);
    localparam logic [3:0]    B_LAST  = 4'd11;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD_K   = 3'd1;
    localparam logic [2:0] LOAD_I   = 3'd2;
    localparam logic [2:0] MAC      = 3'd3;
    localparam logic [2:0] DRAIN    = 3'd4;
    localparam logic [2:0] TURN_ON  = 3'd5;
    localparam logic [2:0] DRIVE    = 3'd6;
    localparam logic [2:0] TURN_OFF = 3'd7;

    logic [2:0]    state_r;
    logic [3:0]    beat_r;
    logic [GW-1:0] grp_r;
    logic [DW-1:0] drain_r;
    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;
    logic [CW-1:0] ch_r;
    logic          ready_s;
    logic          acc_s;

    // Input beats 0..11 map onto four channel slots, three beats each.
    function automatic logic [1:0] idss_slot(input logic [3:0] b);
        logic [1:0] slot;
        case (b)
            4'd0, 4'd1, 4'd2:  slot = 2'd0;
            4'd3, 4'd4, 4'd5:  slot = 2'd1;
            4'd6, 4'd7, 4'd8:  slot = 2'd2;
            default:           slot = 2'd3;
        endcase
        return slot;
    endfunction

    // Output decode from the state register; load enables gated by accepted beat.
    always_comb begin
        ready_s             = (state_r == LOAD_K) || (state_r == LOAD_I);
        acc_s               = bus.con_valid & ready_s;
        bus.con_ready       = ready_s;
        bus.driving_cons    = (state_r == DRIVE);
        bus.output_valid    = (state_r == DRIVE);
        bus.output_x        = (state_r == DRIVE) ? x_r  : {XW{1'b0}};
        bus.output_y        = (state_r == DRIVE) ? y_r  : {YW{1'b0}};
        bus.output_ch       = (state_r == DRIVE) ? ch_r : {CW{1'b0}};
        running             = (state_r != IDLE);
        ctrl_KDS_LE_select  = (acc_s && state_r == LOAD_K) ? (12'd1 << beat_r) : 12'd0;
        ctrl_IDSS_shift     = acc_s && (state_r == LOAD_I);
        ctrl_IDSS_LE_select = (acc_s && state_r == LOAD_I) ? idss_slot(beat_r) : 2'd0;
        ctrl_MAC_en         = (state_r == MAC);
        ctrl_MAC_acc_first  = (state_r == MAC) && (grp_r == {GW{1'b0}});
        ctrl_ODS_shift      = (state_r == DRAIN) && (drain_r == D_LAST);
        ctrl_ODS_sel_out    = (state_r == DRIVE) ? 2'b01 : 2'b00;
    end

    // State transitions and loop-nest counters; con_valid low simply holds everything.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_r <= IDLE;
            beat_r  <= 4'd0;
            grp_r   <= {GW{1'b0}};
            drain_r <= {DW{1'b0}};
            x_r     <= {XW{1'b0}};
            y_r     <= {YW{1'b0}};
            ch_r    <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) state_r <= LOAD_K;
                    else       state_r <= IDLE;
                end
                LOAD_K, LOAD_I: begin
                    if (acc_s) begin
                        if (beat_r == B_LAST) begin
                            beat_r  <= 4'd0;
                            state_r <= (state_r == LOAD_K) ? LOAD_I : MAC;
                        end else begin
                            beat_r  <= beat_r + 4'd1;
                        end
                    end
                end
                MAC: begin
                    if (grp_r == G_LAST) begin
                        grp_r   <= {GW{1'b0}};
                        drain_r <= {DW{1'b0}};
                        state_r <= DRAIN;
                    end else begin
                        grp_r   <= grp_r + GW'(1);
                        state_r <= LOAD_K;
                    end
                end
                DRAIN: begin
                    if (drain_r == D_LAST) begin
                        drain_r <= {DW{1'b0}};
                        state_r <= TURN_ON;
                    end else begin
                        drain_r <= drain_r + DW'(1);
                    end
                end
                TURN_ON: state_r <= DRIVE;
                DRIVE:   state_r <= TURN_OFF;
                TURN_OFF: begin
                    // Channel is the innermost output loop, then x, then y.
                    if (ch_r != CH_LAST) begin
                        ch_r    <= ch_r + CW'(1);
                        state_r <= LOAD_K;
                    end else if (x_r != X_LAST) begin
                        ch_r    <= {CW{1'b0}};
                        x_r     <= x_r + XW'(1);
                        state_r <= LOAD_K;
                    end else if (y_r != Y_LAST) begin
                        ch_r    <= {CW{1'b0}};
                        x_r     <= {XW{1'b0}};
                        y_r     <= y_r + YW'(1);
                        state_r <= LOAD_K;
                    end else begin
                        ch_r    <= {CW{1'b0}};
                        x_r     <= {XW{1'b0}};
                        y_r     <= {YW{1'b0}};
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_conv_ctrl_fsm
// Directed bench for conv_ctrl_fsm on a 2x2x2-output layer. dut has 4 input
// channels (one group), dut8 has 8 (two groups).
// ---------------------------------------------------------------------------
module tb_conv_ctrl_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start8 = 1'b0;

    always #5 clk = ~clk;

    conv_ctrl_fsm_if #(.XW(1), .YW(1), .CW(1)) bus ();
    conv_ctrl_fsm_if #(.XW(1), .YW(1), .CW(1)) bus8 ();

    logic        running, running8;
    logic [11:0] kds, kds8;
    logic [1:0]  idss, idss8, sel, sel8;
    logic        shift, shift8, mac_en, mac_en8, accf, accf8, ods, ods8;

    conv_ctrl_fsm #(.FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .INPUT_NB_CHANNELS(4),
                    .OUTPUT_NB_CHANNELS(2), .MAC_LATENCY(2)) dut (
        .clk(clk), .arst_n_in(rst_n), .start(start), .running(running), .bus(bus),
        .ctrl_KDS_LE_select(kds), .ctrl_IDSS_LE_select(idss), .ctrl_IDSS_shift(shift),
        .ctrl_MAC_en(mac_en), .ctrl_MAC_acc_first(accf), .ctrl_ODS_shift(ods),
        .ctrl_ODS_sel_out(sel)
    );

    conv_ctrl_fsm #(.FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .INPUT_NB_CHANNELS(8),
                    .OUTPUT_NB_CHANNELS(2), .MAC_LATENCY(2)) dut8 (
        .clk(clk), .arst_n_in(rst_n), .start(start8), .running(running8), .bus(bus8),
        .ctrl_KDS_LE_select(kds8), .ctrl_IDSS_LE_select(idss8), .ctrl_IDSS_shift(shift8),
        .ctrl_MAC_en(mac_en8), .ctrl_MAC_acc_first(accf8), .ctrl_ODS_shift(ods8),
        .ctrl_ODS_sel_out(sel8)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic r, input logic rdy, input logic drv,
                                       input logic v, input logic [11:0] k, input logic [1:0] i,
                                       input logic sh, input logic me, input logic af,
                                       input logic od, input logic [1:0] s, input logic xx,
                                       input logic yy, input logic cc);
        return {5'd0, r, rdy, drv, v, k, i, sh, me, af, od, s, xx, yy, cc};
    endfunction

    function automatic logic [31:0] obs();
        return mk(running, bus.con_ready, bus.driving_cons, bus.output_valid, kds, idss,
                  shift, mac_en, accf, ods, sel, bus.output_x, bus.output_y, bus.output_ch);
    endfunction

    function automatic logic [31:0] obs8();
        return mk(running8, bus8.con_ready, bus8.driving_cons, bus8.output_valid, kds8, idss8,
                  shift8, mac_en8, accf8, ods8, sel8, bus8.output_x, bus8.output_y, bus8.output_ch);
    endfunction

    // Bus-turnaround monitor: no ready while driving, nor in the adjacent cycles.
    logic prev_rdy = 1'b0;
    logic prev_drv = 1'b0;
    int   viol = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rdy <= 1'b0;
            prev_drv <= 1'b0;
        end else begin
            if ((bus.con_ready && bus.driving_cons) || (prev_rdy && bus.driving_cons) ||
                (prev_drv && bus.con_ready))
                viol <= viol + 1;
            prev_rdy <= bus.con_ready;
            prev_drv <= bus.driving_cons;
        end
    end

    typedef struct {
        logic        cv;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [30];

    initial begin
        int n, kc, ic, mc, d8, s, u;
        logic [11:0] ek;
        logic found;

        // One full output period (single group, MAC_LATENCY=2), from the first LOAD_K cycle.
        for (int k = 0; k < 30; k++) begin
            tbl[k].cv  = 1'b1;
            tbl[k].exp = mk(1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 12; k++)
            tbl[k].exp = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'd1 << k, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 12; k < 24; k++)
            tbl[k].exp = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 2'((k - 12) / 3), 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        tbl[24].exp = mk(1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        tbl[26].exp = mk(1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        tbl[28].exp = mk(1'b1, 1'b0, 1'b1, 1'b1, 12'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);

        bus.con_valid  = 1'b0;
        bus8.con_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset, no start.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            chk("idle_outputs", obs(), 32'd0);
            chk("idle_outputs8", obs8(), 32'd0);
        end

        // Full layer, con_valid held high: first output period from the table.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) @(negedge clk);
            bus.con_valid = tbl[k].cv;
            #1;
            chk($sformatf("vec_%0d", k), obs(), tbl[k].exp);
        end

        // Remaining seven results: order, spacing, ignored re-start, running fall.
        n = 1;
        for (int t = 30; t <= 240; t++) begin
            @(negedge clk); #1;
            start = (t == 48);
            if (bus.output_valid) begin
                chk("drive_cycle", 32'(t), 32'(28 + 30 * n));
                chk("drive_xyc", {29'd0, bus.output_x, bus.output_y, bus.output_ch},
                    {29'd0, 1'(n / 2), 1'(n / 4), 1'(n)});
                n++;
            end
            if (t == 239) chk("running_last_turn_off", 32'(running), 32'd1);
            if (t == 240) chk("idle_after_layer", obs(), 32'd0);
        end
        start = 1'b0;
        chk("drive_count", 32'(n), 32'd8);

        // Stalled layer: con_valid 1,0,0,1,0,0,...
        n = 0; kc = 0; ic = 0; s = 0;
        while (!(n == 8 && !running && s > 2) && s < 3000) begin
            @(negedge clk);
            start = (s == 0);
            bus.con_valid = (s % 3 == 0);
            #1;
            if (kds != 12'd0) begin
                ek = 12'd1 << (kc % 12);
                chk("stall_kds_on_acc", 32'(bus.con_valid & bus.con_ready), 32'd1);
                chk("stall_kds_walk", 32'(kds), 32'(ek));
                kc++;
            end
            if (shift) begin
                chk("stall_idss_on_acc", 32'(bus.con_valid & bus.con_ready), 32'd1);
                chk("stall_idss_sel", 32'(idss), 32'((ic % 12) / 3));
                ic++;
            end else begin
                chk("stall_idss_sel_idle", 32'(idss), 32'd0);
            end
            if (bus.output_valid) begin
                chk("stall_drive_xyc", {29'd0, bus.output_x, bus.output_y, bus.output_ch},
                    {29'd0, 1'(n / 2), 1'(n / 4), 1'(n)});
                n++;
            end
            s++;
        end
        start = 1'b0;
        chk("stall_timeout", 32'(s < 3000), 32'd1);
        chk("stall_kds_beats", 32'(kc), 32'd96);
        chk("stall_idss_beats", 32'(ic), 32'd96);
        chk("stall_drive_count", 32'(n), 32'd8);

        // Two input groups: acc_first alternates 1,0; one result per output.
        bus8.con_valid = 1'b1;
        mc = 0; d8 = 0; u = 0;
        while (!(d8 == 8 && !running8 && u > 2) && u < 1000) begin
            @(negedge clk);
            start8 = (u == 0);
            #1;
            if (mac_en8) begin
                chk("grp_acc_first", 32'(accf8), 32'(mc % 2 == 0));
                mc++;
            end
            if (bus8.output_valid) begin
                if (d8 == 0) chk("grp_first_drive_cycle", 32'(u), 32'd54);
                d8++;
            end
            u++;
        end
        start8 = 1'b0;
        chk("grp_timeout", 32'(u < 1000), 32'd1);
        chk("grp_mac_pulses", 32'(mc), 32'd16);
        chk("grp_drive_count", 32'(d8), 32'd8);

        chk("bus_turnaround_violations", 32'(viol), 32'd0);

        // Reset asserted while driving: bus released at once, back to idle.
        @(negedge clk);
        bus.con_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int w = 0; w < 100 && !found; w++) begin
            @(negedge clk); #1;
            if (bus.output_valid) found = 1'b1;
        end
        chk("abort_reach_drive", 32'(found), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_driving_released", 32'(bus.driving_cons), 32'd0);
        chk("abort_outputs", obs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("post_abort_idle", obs(), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
